// File: rtl/axis_rr_arb_pkt.sv
// axis_rr_arb_pkt: round-robin arbiter merging MASTER_NUM AXI-Stream inputs
// into one registered output. m_tuser carries the source channel index.
//
// Build option: define AXIS_RR_ARB_PKT_LOCK_EN to hold the grant on one
// channel from its first beat until its tlast beat (packet lock). Without
// the macro the arbiter re-arbitrates on every beat and tlast is passed
// through unchanged.
module axis_rr_arb_pkt #(
    parameter int MASTER_NUM = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [MASTER_NUM*DATA_WIDTH-1:0] s_tdata,
    input  logic [MASTER_NUM-1:0]            s_tvalid,
    input  logic [MASTER_NUM-1:0]            s_tlast,
    output logic [MASTER_NUM-1:0]            s_tready,
    output logic [DATA_WIDTH-1:0]            m_tdata,
    output logic                             m_tvalid,
    output logic                             m_tlast,
    output logic [ID_WIDTH-1:0]              m_tuser,
    input  logic                             m_tready
);

    // Output register slice
    logic [DATA_WIDTH-1:0] m_tdata_q,  m_tdata_d;
    logic                  m_tvalid_q, m_tvalid_d;
    logic                  m_tlast_q,  m_tlast_d;
    logic [ID_WIDTH-1:0]   m_tuser_q,  m_tuser_d;

    // Round-robin pointer: first channel searched on the next arbitration
    logic [ID_WIDTH-1:0]   ptr_q, ptr_d;

`ifdef AXIS_RR_ARB_PKT_LOCK_EN
    // Packet lock: grant stays on lock_id_q while lock_q is set
    logic                  lock_q,    lock_d;
    logic [ID_WIDTH-1:0]   lock_id_q, lock_id_d;
`endif

    logic                  ld;        // output register may load this cycle
    logic                  gnt_vld;   // some channel holds the grant
    logic [ID_WIDTH-1:0]   gnt_idx;   // index of the granted channel
    logic [MASTER_NUM-1:0] grant;
    logic                  hs;        // a beat is accepted this cycle
    logic [ID_WIDTH-1:0]   next_idx;  // gnt_idx + 1 modulo MASTER_NUM
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_last;

    // The slice accepts a new beat when empty or when its beat leaves now
    assign ld = ~m_tvalid_q | m_tready;

    // Arbitration: first valid channel from ptr_q upward, or the locked one
    always_comb begin
        int cand;
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int k = 0; k < MASTER_NUM; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= MASTER_NUM) begin
                cand = cand - MASTER_NUM;
            end
            if (!gnt_vld && s_tvalid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = ID_WIDTH'(cand);
            end
        end
`ifdef AXIS_RR_ARB_PKT_LOCK_EN
        // A locked channel that is idle leaves a bubble rather than yielding
        if (lock_q) begin
            gnt_vld = s_tvalid[lock_id_q];
            gnt_idx = lock_id_q;
        end
`endif
    end

    // One-hot grant, ready gating and selected-beat muxing
    always_comb begin
        grant = '0;
        if (gnt_vld) begin
            grant[gnt_idx] = 1'b1;
        end
        // Ready is forced low while rst is sampled so no beat is lost
        s_tready = grant & {MASTER_NUM{ld & ~rst}};
        hs       = gnt_vld & ld & ~rst;
        sel_data = s_tdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        sel_last = s_tlast[gnt_idx];
        next_idx = (gnt_idx == ID_WIDTH'(MASTER_NUM - 1)) ? '0 : gnt_idx + 1'b1;
    end

    // Next-state for output slice, pointer and lock
    always_comb begin
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        m_tuser_d  = m_tuser_q;
        ptr_d      = ptr_q;
`ifdef AXIS_RR_ARB_PKT_LOCK_EN
        lock_d     = lock_q;
        lock_id_d  = lock_id_q;
`endif
        if (ld) begin
            // Slice empties when nothing is granted; holds while stalled
            m_tvalid_d = hs;
            if (hs) begin
                m_tdata_d = sel_data;
                m_tlast_d = sel_last;
                m_tuser_d = gnt_idx;
            end
        end
        if (hs) begin
`ifdef AXIS_RR_ARB_PKT_LOCK_EN
            // The pointer only advances when the packet ends; a single-beat
            // packet never locks
            if (sel_last) begin
                lock_d = 1'b0;
                ptr_d  = next_idx;
            end else begin
                lock_d    = 1'b1;
                lock_id_d = gnt_idx;
            end
`else
            ptr_d = next_idx;
`endif
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all
        // registers update together from values computed before the edge.
        if (rst) begin
            // NOTE: the data register is reset too, so the output bus reads
            // as zero straight after reset instead of carrying a stale beat.
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tuser_q  <= '0;
            ptr_q      <= '0;
`ifdef AXIS_RR_ARB_PKT_LOCK_EN
            lock_q     <= 1'b0;
            lock_id_q  <= '0;
`endif
        end else begin
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            m_tuser_q  <= m_tuser_d;
            ptr_q      <= ptr_d;
`ifdef AXIS_RR_ARB_PKT_LOCK_EN
            lock_q     <= lock_d;
            lock_id_q  <= lock_id_d;
`endif
        end
    end

    assign m_tdata  = m_tdata_q;
    assign m_tvalid = m_tvalid_q;
    assign m_tlast  = m_tlast_q;
    assign m_tuser  = m_tuser_q;

endmodule

// File: tb/tb_axis_rr_arb_pkt.sv
// Directed bench for axis_rr_arb_pkt (4 channels, 32-bit data). Expected
// values are hand-computed per build: lock-enabled tables apply when
// AXIS_RR_ARB_PKT_LOCK_EN is defined, per-beat tables otherwise.
module tb_axis_rr_arb_pkt;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*DW-1:0] s_tdata;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tlast;
    logic [N-1:0]    s_tready;
    logic [DW-1:0]   m_tdata;
    logic            m_tvalid;
    logic            m_tlast;
    logic [IW-1:0]   m_tuser;
    logic            m_tready;

    logic [DW-1:0] chan_data [N];

    typedef struct {
        logic          rst;
        logic [N-1:0]  vld;
        logic [N-1:0]  last;
        logic          mrdy;
        logic [N-1:0]  exp_srdy;   // s_tready in the cycle the inputs apply
        logic          exp_mv;     // m_tvalid after the following edge
        logic [IW-1:0] exp_user;
        logic          exp_mlast;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_err    = 0;

    axis_rr_arb_pkt #(.MASTER_NUM(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tlast  (m_tlast),
        .m_tuser  (m_tuser),
        .m_tready (m_tready)
    );

    always #5 clk = ~clk;

    assign s_tdata = {chan_data[3], chan_data[2], chan_data[1], chan_data[0]};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [N-1:0] v, input logic [N-1:0] l,
                       input logic mr, input logic [N-1:0] es, input logic ev,
                       input logic [IW-1:0] eu, input logic el);
        vec_t t;
        t.rst = r; t.vld = v; t.last = l; t.mrdy = mr;
        t.exp_srdy = es; t.exp_mv = ev; t.exp_user = eu; t.exp_mlast = el;
        vecs.push_back(t);
    endtask

    initial begin
        chan_data[0] = 32'h1111_0000;
        chan_data[1] = 32'h2222_0001;
        chan_data[2] = 32'h3333_0002;
        chan_data[3] = 32'hA5A5_A5A5;
        rst = 1'b1; s_tvalid = '0; s_tlast = '0; m_tready = 1'b1;

        // Reset with every channel requesting: no ready, outputs zero
        add(1, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 0);
        // All channels valid, single-beat packets: 0,1,2,3,0 without bubbles
        add(0, 4'b1111, 4'b1111, 1, 4'b0001, 1, 0, 1);
        add(0, 4'b1111, 4'b1111, 1, 4'b0010, 1, 1, 1);
        add(0, 4'b1111, 4'b1111, 1, 4'b0100, 1, 2, 1);
        add(0, 4'b1111, 4'b1111, 1, 4'b1000, 1, 3, 1);
        add(0, 4'b1111, 4'b1111, 1, 4'b0001, 1, 0, 1);

        // Ch1 3-beat packet against ch0/ch2; one ch0 beat first moves ptr to 1
        add(1, 4'b0111, 4'b0101, 1, 4'b0000, 0, 0, 0);
        add(0, 4'b0111, 4'b0101, 1, 4'b0001, 1, 0, 1);
`ifdef AXIS_RR_ARB_PKT_LOCK_EN
        add(0, 4'b0111, 4'b0101, 1, 4'b0010, 1, 1, 0);
        add(0, 4'b0111, 4'b0101, 1, 4'b0010, 1, 1, 0);
        add(0, 4'b0111, 4'b0111, 1, 4'b0010, 1, 1, 1);
        add(0, 4'b0101, 4'b0101, 1, 4'b0100, 1, 2, 1);
        add(0, 4'b0101, 4'b0101, 1, 4'b0001, 1, 0, 1);
`else
        add(0, 4'b0111, 4'b0101, 1, 4'b0010, 1, 1, 0);
        add(0, 4'b0111, 4'b0101, 1, 4'b0100, 1, 2, 1);
        add(0, 4'b0111, 4'b0101, 1, 4'b0001, 1, 0, 1);
        add(0, 4'b0111, 4'b0101, 1, 4'b0010, 1, 1, 0);
        add(0, 4'b0111, 4'b0101, 1, 4'b0100, 1, 2, 1);
        add(0, 4'b0111, 4'b0101, 1, 4'b0001, 1, 0, 1);
        add(0, 4'b0111, 4'b0111, 1, 4'b0010, 1, 1, 1);
        add(0, 4'b0101, 4'b0101, 1, 4'b0100, 1, 2, 1);
`endif

        // Ch2 starts a packet, then idles 3 cycles while ch0 requests
        add(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);
        add(0, 4'b0100, 4'b0000, 1, 4'b0100, 1, 2, 0);
`ifdef AXIS_RR_ARB_PKT_LOCK_EN
        add(0, 4'b0001, 4'b0000, 1, 4'b0000, 0, 0, 0);
        add(0, 4'b0001, 4'b0000, 1, 4'b0000, 0, 0, 0);
        add(0, 4'b0001, 4'b0000, 1, 4'b0000, 0, 0, 0);
        add(0, 4'b0101, 4'b0100, 1, 4'b0100, 1, 2, 1);
        add(0, 4'b0001, 4'b0101, 1, 4'b0001, 1, 0, 1);
`else
        add(0, 4'b0001, 4'b0001, 1, 4'b0001, 1, 0, 1);
        add(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);
        add(0, 4'b0101, 4'b0100, 1, 4'b0100, 1, 2, 1);
`endif

        // Reset in the middle of a ch1 packet: restart from ch0
        add(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);
        add(0, 4'b0010, 4'b0000, 1, 4'b0010, 1, 1, 0);
        add(1, 4'b0011, 4'b0001, 1, 4'b0000, 0, 0, 0);
        add(0, 4'b0011, 4'b0001, 1, 4'b0001, 1, 0, 1);

        // Table replay: inputs after one edge, ready checked mid-cycle,
        // registered outputs checked just after the next edge
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; s_tvalid = vecs[i].vld;
            s_tlast = vecs[i].last; m_tready = vecs[i].mrdy;
            #1;
            check($sformatf("v%0d s_tready", i), 32'(s_tready), 32'(vecs[i].exp_srdy));
            @(posedge clk); #1;
            check($sformatf("v%0d m_tvalid", i), 32'(m_tvalid), 32'(vecs[i].exp_mv));
            if (vecs[i].exp_mv) begin
                check($sformatf("v%0d m_tuser", i), 32'(m_tuser), 32'(vecs[i].exp_user));
                check($sformatf("v%0d m_tlast", i), 32'(m_tlast), 32'(vecs[i].exp_mlast));
                check($sformatf("v%0d m_tdata", i), m_tdata, chan_data[vecs[i].exp_user]);
            end
            if (vecs[i].rst) begin
                check($sformatf("v%0d rst m_tdata", i), m_tdata, 32'h0);
                check($sformatf("v%0d rst m_tuser", i), 32'(m_tuser), 32'h0);
                check($sformatf("v%0d rst m_tlast", i), 32'(m_tlast), 32'h0);
            end
        end

        // Backpressure: ch3 beat held 5 cycles, then released exactly once
        rst = 1'b1; s_tvalid = '0; s_tlast = '0; m_tready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; s_tvalid = 4'b1000; s_tlast = 4'b1000;
        #1;
        check("stall load s_tready", 32'(s_tready), 32'h8);
        @(posedge clk); #1;
        check("stall load m_tvalid", 32'(m_tvalid), 32'h1);
        check("stall load m_tdata", m_tdata, 32'hA5A5_A5A5);
        m_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("stall%0d s_tready", k), 32'(s_tready), 32'h0);
            @(posedge clk); #1;
            check($sformatf("stall%0d m_tvalid", k), 32'(m_tvalid), 32'h1);
            check($sformatf("stall%0d m_tdata", k), m_tdata, 32'hA5A5_A5A5);
            check($sformatf("stall%0d m_tuser", k), 32'(m_tuser), 32'h3);
        end
        m_tready = 1'b1;
        #1;
        check("release s_tready", 32'(s_tready), 32'h8);
        @(posedge clk); #1;
        check("release m_tvalid", 32'(m_tvalid), 32'h1);
        check("release m_tdata", m_tdata, 32'hA5A5_A5A5);
        s_tvalid = '0;
        #1;
        check("drain s_tready", 32'(s_tready), 32'h0);
        @(posedge clk); #1;
        check("drain m_tvalid", 32'(m_tvalid), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
